// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings and default width for the multiply/divide sequencer
package muldiv_pkg;
  localparam int MD_DATA_W = 32;
  typedef enum logic [1:0] {MD_MUL, MD_MULHU, MD_DIVU, MD_REMU} md_op_e;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} md_state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (multiply) or restoring-subtract (divide) iteration
// Ports: is_div selects divide; acc = product or {rem,quo}; opnd = shifted multiplicand or divisor;
//        mplr = remaining multiplier; *_n are the next-iteration values.
module muldiv_step import muldiv_pkg::*; #(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic                  is_div,
  input  logic [2*DATA_W-1:0]   acc,
  input  logic [2*DATA_W-1:0]   opnd,
  input  logic [DATA_W-1:0]     mplr,
  output logic [2*DATA_W-1:0]   acc_n,
  output logic [2*DATA_W-1:0]   opnd_n,
  output logic [DATA_W-1:0]     mplr_n
);
  logic [DATA_W:0] trial;
  always_comb begin
    // Remainder after the left shift can need DATA_W+1 bits, so take it straight from acc.
    trial  = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd[DATA_W-1:0]};
    acc_n  = is_div ? {trial[DATA_W] ? acc[2*DATA_W-2:DATA_W-1] : trial[DATA_W-1:0], acc[DATA_W-2:0], ~trial[DATA_W]}
                    : acc + (mplr[0] ? opnd : '0);
    opnd_n = is_div ? opnd : opnd << 1;
    mplr_n = is_div ? mplr : mplr >> 1;
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MUL/MULHU/DIVU/REMU unit that stalls the ALU stage while busy
// Ports: clk, reset (async, active-high); start/op/opA/opB issue an op; flush kills it;
//        stall holds the ALU stage; busy = not idle; done pulses with result/div_zero.
// Optional: define MULDIV_EARLY_OUT_EN to finish multiplies once the remaining multiplier is zero.
module muldiv_sequencer import muldiv_pkg::*; #(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  input  logic              flush,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_zero
);
  md_state_e           state;
  md_op_e              op_r;
  logic [CNT_W-1:0]    cnt;
  logic [2*DATA_W-1:0] acc, opnd, acc_n, opnd_n;
  logic [DATA_W-1:0]   mplr, mplr_n;
  logic                last;
  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div (op_r[1]),
    .acc    (acc),
    .opnd   (opnd),
    .mplr   (mplr),
    .acc_n  (acc_n),
    .opnd_n (opnd_n),
    .mplr_n (mplr_n)
  );
`ifdef MULDIV_EARLY_OUT_EN
  assign last = cnt == CNT_W'(DATA_W-1) || (!op_r[1] && mplr_n == '0);
`else
  assign last = cnt == CNT_W'(DATA_W-1);
`endif
  assign busy  = state != ST_IDLE;
  assign stall = state == ST_CALC || (state == ST_IDLE && start);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_r     <= MD_MUL;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      mplr     <= '0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
      if (flush) state <= ST_IDLE;
      else case (state)
        ST_IDLE: if (start) begin
          op_r <= md_op_e'(op);
          cnt  <= '0;
          acc  <= op[1] ? {{DATA_W{1'b0}}, opA} : '0;
          opnd <= {{DATA_W{1'b0}}, op[1] ? opB : opA};
          mplr <= opB;
          if (op[1] && opB == '0) begin
            state    <= ST_DONE;
            done     <= 1'b1;
            div_zero <= 1'b1;
            result   <= op[0] ? opA : '1;
          end else state <= ST_CALC;
        end
        ST_CALC: begin
          acc  <= acc_n;
          opnd <= opnd_n;
          mplr <= mplr_n;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            // MUL/DIVU take the low word, MULHU/REMU the high word
            result <= op_r[0] ? acc_n[2*DATA_W-1:DATA_W] : acc_n[DATA_W-1:0];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic        clk = 0, reset = 1, start = 0, flush = 0;
  logic [1:0]  op = 0;
  logic [31:0] opA = 0, opB = 0, result;
  logic        stall, busy, done, div_zero;
  int total = 0, bad = 0;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opA(opA), .opB(opB), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic int mul_lat(input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    int n = 1;
    for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  task automatic wait_done(output int lat, output bit stall_ok);
    lat = -1;
    stall_ok = 1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin lat = k; break; end
      if (!stall) stall_ok = 0;
    end
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic edz, input int elat, input string nm);
    int lat;
    bit sok;
    @(negedge clk);
    op = o; opA = a; opB = b; start = 1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL %s stall0 got=%b want=1", nm, stall); end
    wait_done(lat, sok);
    total++; if (lat != elat) begin bad++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, elat); end
    total++; if (!sok) begin bad++; $display("FAIL %s stall_while_busy got=0 want=1", nm); end
    total++; if (result !== er) begin bad++; $display("FAIL %s result got=%h want=%h", nm, result, er); end
    total++; if (div_zero !== edz) begin bad++; $display("FAIL %s div_zero got=%b want=%b", nm, div_zero, edz); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL %s stall_at_done got=%b want=0", nm, stall); end
    start = 0;
    @(negedge clk);
    total++; if ({done, busy, div_zero} !== 3'b000 || result !== 32'h0) begin
      bad++; $display("FAIL %s after_done done/busy/dz=%b result=%h want 000/0", nm, {done, busy, div_zero}, result);
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if ({stall, busy, done, div_zero} !== 4'b0000) begin bad++; $display("FAIL reset flags got=%b want=0000", {stall, busy, done, div_zero}); end
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset result got=%h want=0", result); end
    @(negedge clk); reset = 0;
  endtask

  task automatic test_mul();
    do_op(2'b00, 32'd7, 32'd6, 32'd42, 1'b0, mul_lat(32'd6), "mul_7x6");
    do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, "mulhu_ff");
    do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, "mul_ff");
    do_op(2'b00, 32'd3, 32'd2, 32'd6, 1'b0, mul_lat(32'd2), "mul_3x2");
    do_op(2'b01, 32'h12345678, 32'd0, 32'd0, 1'b0, mul_lat(32'd0), "mulhu_x0");
  endtask

  task automatic test_div();
    do_op(2'b10, 32'd100, 32'd7, 32'd14, 1'b0, 33, "divu_100_7");
    do_op(2'b11, 32'd100, 32'd7, 32'd2, 1'b0, 33, "remu_100_7");
    do_op(2'b10, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 1'b0, 33, "divu_ff_1");
    do_op(2'b11, 32'd3, 32'd10, 32'd3, 1'b0, 33, "remu_3_10");
  endtask

  task automatic test_div_zero();
    do_op(2'b10, 32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, 1, "divu_5_0");
    do_op(2'b11, 32'd5, 32'd0, 32'd5, 1'b1, 1, "remu_5_0");
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    op = 2'b00; opA = 32'd7; opB = 32'hFFFF; start = 1;
    repeat (10) @(negedge clk);
    start = 0; flush = 1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_calc busy=%b done=%b want 0/0", busy, done); end
    flush = 0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL flush_no_done got=1 want=0"); end
    start = 1; flush = 1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL flush_idle busy=%b done=%b want 0/0", busy, done); end
    start = 0; flush = 0;
    do_op(2'b00, 32'd3, 32'd3, 32'd9, 1'b0, mul_lat(32'd3), "mul_after_flush");
  endtask

  task automatic test_back_to_back();
    int lat;
    bit sok;
    @(negedge clk);
    op = 2'b10; opA = 32'd100; opB = 32'd7; start = 1;
    wait_done(lat, sok);
    total++; if (result !== 32'd14) begin bad++; $display("FAIL b2b_first result got=%h want=%h", result, 32'd14); end
    op = 2'b11;
    @(negedge clk);
    total++; if ({done, busy, stall} !== 3'b001) begin bad++; $display("FAIL b2b_idle done/busy/stall got=%b want=001", {done, busy, stall}); end
    wait_done(lat, sok);
    total++; if (lat != 33) begin bad++; $display("FAIL b2b_latency got=%0d want=33", lat); end
    total++; if (result !== 32'd2) begin bad++; $display("FAIL b2b_second result got=%h want=%h", result, 32'd2); end
    start = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    op = 2'b00; opA = 32'd9; opB = 32'hFFFFFFFF; start = 1;
    repeat (5) @(negedge clk);
    start = 0; reset = 1;
    #1;
    total++; if ({stall, busy, done, div_zero} !== 4'b0000 || result !== 32'h0) begin
      bad++; $display("FAIL reset_mid flags=%b result=%h want 0000/0", {stall, busy, done, div_zero}, result);
    end
    @(negedge clk); reset = 0;
    seen = 0;
    repeat (40) begin @(negedge clk); if (done || busy) seen = 1; end
    total++; if (seen) begin bad++; $display("FAIL reset_mid_no_done got=1 want=0"); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    do_op(2'b00, 32'd3, 32'd2, 32'd6, 1'b0, mul_lat(32'd2), "mul_after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
